// File: rtl/sdr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdr_pkg : register map, destination encoding and helpers shared by SDR muxes
// rev 1.0
// ---------------------------------------------------------------------------
package sdr_pkg;

  localparam logic [11:0] REG_CTRL        = 12'h000;
  localparam logic [11:0] REG_STATUS      = 12'h004;
  localparam logic [11:0] REG_RX_BYTES    = 12'h010;
  localparam logic [11:0] REG_RX_FRAMES   = 12'h014;
  localparam logic [11:0] REG_DROP_FRAMES = 12'h018;

  typedef enum logic [1:0] {
    DST_DMA  = 2'd0,
    DST_ALT  = 2'd1,
    DST_DROP = 2'd2
  } dst_e;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  function automatic dst_e dst_decode(input logic [3:0] sel);
    case (sel)
      4'd0:    return DST_DMA;
      4'd1:    return DST_ALT;
      default: return DST_DROP;
    endcase
  endfunction

  function automatic logic [31:0] popcount(input logic [63:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_rx_demux_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdr_axil_if / sdr_axis_if : AXI4-Lite and AXI-Stream bundles with modports
// rev 1.0
// ---------------------------------------------------------------------------
interface sdr_axil_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface sdr_axis_if #(parameter int BYTES = 8);
  logic [8*BYTES-1:0] tdata;
  logic [BYTES-1:0]   tkeep;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/sdr_axil_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdr_axil_regs : AXI4-Lite slave with CTRL/STATUS and read-only counters
// rev 1.0
// ---------------------------------------------------------------------------
module sdr_axil_regs
  import sdr_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 12,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  sdr_axil_if.slave   s_axil,
  output logic        o_ctrl_enable,
  output logic [3:0]  o_ctrl_dst_sel,
  input  logic        i_in_frame,
  input  logic        i_running_set,
  input  logic [31:0] i_rx_bytes,
  input  logic [31:0] i_rx_frames,
  input  logic [31:0] i_drop_frames
);

  logic                       r_aw_held;
  logic                       r_w_held;
  logic [AXIL_ADDR_WIDTH-1:0] r_awaddr;
  logic                       r_wd_b0;
  logic [3:0]                 r_wd_sel;
  logic                       r_wstrb0;
  logic                       r_bvalid;
  logic                       r_rvalid;
  logic [AXIL_DATA_WIDTH-1:0] r_rdata;
  logic                       r_enable;
  logic [3:0]                 r_dst_sel;
  logic                       r_running;

  logic                       w_commit;
  logic                       w_wr_ctrl;
  logic                       w_w1c_run;
  logic [15:0]                w_araddr16;
  logic [31:0]                w_rd_mux;

  // AW and W park independently; the write fires once both are parked and B is free
  assign w_commit  = r_aw_held && r_w_held && !r_bvalid;
  assign w_wr_ctrl = w_commit && r_wstrb0 && (r_awaddr[11:0] == REG_CTRL);
  assign w_w1c_run = w_commit && r_wstrb0 && r_wd_b0 && (r_awaddr[11:0] == REG_STATUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wd_b0   <= 1'b0;
      r_wd_sel  <= 4'd0;
      r_wstrb0  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      if (s_axil.awvalid && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axil.awaddr;
      end else if (w_commit) begin
        r_aw_held <= 1'b0;
      end
      if (s_axil.wvalid && !r_w_held) begin
        r_w_held <= 1'b1;
        r_wd_b0  <= s_axil.wdata[0];
        r_wd_sel <= s_axil.wdata[7:4];
        r_wstrb0 <= s_axil.wstrb[0];
      end else if (w_commit) begin
        r_w_held <= 1'b0;
      end
      if (w_commit) r_bvalid <= 1'b1;
      else if (s_axil.bready) r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable  <= 1'b0;
      r_dst_sel <= 4'd0;
      r_running <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable  <= r_wd_b0;
        r_dst_sel <= r_wd_sel;
      end
      // a beat landing in the same cycle as the W1C keeps RUNNING set
      if (i_running_set) r_running <= 1'b1;
      else if (w_w1c_run) r_running <= 1'b0;
    end
  end

  assign w_araddr16 = 16'(s_axil.araddr);

  always_comb begin
    w_rd_mux = 32'hDEAD_0000 | {16'h0000, w_araddr16};
    case (s_axil.araddr[11:0])
      REG_CTRL:        w_rd_mux = {24'h0, r_dst_sel, 3'b000, r_enable};
      REG_STATUS:      w_rd_mux = {30'h0, i_in_frame, r_running};
      REG_RX_BYTES:    w_rd_mux = i_rx_bytes;
      REG_RX_FRAMES:   w_rd_mux = i_rx_frames;
      REG_DROP_FRAMES: w_rd_mux = i_drop_frames;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (s_axil.arvalid && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= AXIL_DATA_WIDTH'(w_rd_mux);
    end else if (r_rvalid && s_axil.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axil.awready = !r_aw_held;
  assign s_axil.wready  = !r_w_held;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = 2'b00;
  assign s_axil.arready = !r_rvalid;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rdata   = 32'(r_rdata);
  assign s_axil.rresp   = 2'b00;

  assign o_ctrl_enable  = r_enable;
  assign o_ctrl_dst_sel = r_dst_sel;

endmodule
`default_nettype wire

// File: rtl/sdr_rx_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdr_rx_demux : routes whole RX frames to DMA, ALT or drop via one output slot
// rev 1.0
// ---------------------------------------------------------------------------
module sdr_rx_demux
  import sdr_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 12,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIS_BYTES      = 8
) (
  input  logic        clk,
  input  logic        rst,
  sdr_axil_if.slave   s_axil,
  sdr_axis_if.slave   s_axis_rx,
  sdr_axis_if.master  m_axis_dma,
  sdr_axis_if.master  m_axis_alt
);

  localparam int c_DATA_W = 8 * AXIS_BYTES;

  logic                  w_ctrl_enable;
  logic [3:0]            w_ctrl_sel;
  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  dst_e                  r_act_dst;
  dst_e                  w_cfg_dst;
  dst_e                  w_dst;

  logic [c_DATA_W-1:0]   r_data_q;
  logic [AXIS_BYTES-1:0] r_keep_q;
  logic                  r_last_q;
  dst_e                  r_dst_q;
  logic                  r_valid_q;

  logic                  w_sink_ready;
  logic                  w_can_load;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_unload;

  logic [31:0]           r_rx_bytes;
  logic [31:0]           r_rx_frames;
  logic [31:0]           r_drop_frames;

  sdr_axil_regs #(
    .AXIL_ADDR_WIDTH (AXIL_ADDR_WIDTH),
    .AXIL_DATA_WIDTH (AXIL_DATA_WIDTH)
  ) u_regs (
    .clk            (clk),
    .rst            (rst),
    .s_axil         (s_axil),
    .o_ctrl_enable  (w_ctrl_enable),
    .o_ctrl_dst_sel (w_ctrl_sel),
    .i_in_frame     (r_state == ST_IN_FRAME),
    .i_running_set  (w_accept),
    .i_rx_bytes     (r_rx_bytes),
    .i_rx_frames    (r_rx_frames),
    .i_drop_frames  (r_drop_frames)
  );

  // IDLE has no latched destination yet, so CTRL is used live
  assign w_cfg_dst    = dst_decode(w_ctrl_sel);
  assign w_dst        = (r_state == ST_IN_FRAME) ? r_act_dst : w_cfg_dst;
  assign w_sink_ready = (r_dst_q == DST_DMA) ? m_axis_dma.tready :
                        (r_dst_q == DST_ALT) ? m_axis_alt.tready : 1'b0;
  assign w_unload     = r_valid_q && w_sink_ready;
  assign w_can_load   = !r_valid_q || w_sink_ready;
  assign w_accept     = s_axis_rx.tvalid && w_tready;
  assign w_load       = w_accept && (w_dst != DST_DROP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_act_dst <= DST_DMA;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_accept) r_act_dst <= w_cfg_dst;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept && !s_axis_rx.tlast) w_state_next = ST_IN_FRAME;
      ST_IN_FRAME: if (w_accept && s_axis_rx.tlast)  w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tready = 1'b0;
    if (r_state == ST_IDLE && !w_ctrl_enable) w_tready = 1'b0;
    else if (w_dst == DST_DROP)               w_tready = 1'b1;
    else                                      w_tready = w_can_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_keep_q  <= '0;
      r_last_q  <= 1'b0;
      r_dst_q   <= DST_DMA;
    end else if (w_load) begin
      r_valid_q <= 1'b1;
      r_data_q  <= s_axis_rx.tdata;
      r_keep_q  <= s_axis_rx.tkeep;
      r_last_q  <= s_axis_rx.tlast;
      r_dst_q   <= w_dst;
    end else if (w_unload) begin
      r_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_bytes    <= 32'd0;
      r_rx_frames   <= 32'd0;
      r_drop_frames <= 32'd0;
    end else if (w_accept) begin
      r_rx_bytes <= r_rx_bytes + popcount(64'(s_axis_rx.tkeep));
      if (s_axis_rx.tlast && w_dst == DST_DROP) r_drop_frames <= r_drop_frames + 32'd1;
      if (s_axis_rx.tlast && w_dst != DST_DROP) r_rx_frames   <= r_rx_frames + 32'd1;
    end
  end

  assign s_axis_rx.tready  = w_tready;

  assign m_axis_dma.tvalid = r_valid_q && (r_dst_q == DST_DMA);
  assign m_axis_dma.tdata  = r_data_q;
  assign m_axis_dma.tkeep  = r_keep_q;
  assign m_axis_dma.tlast  = r_last_q;
  assign m_axis_alt.tvalid = r_valid_q && (r_dst_q == DST_ALT);
  assign m_axis_alt.tdata  = r_data_q;
  assign m_axis_alt.tkeep  = r_keep_q;
  assign m_axis_alt.tlast  = r_last_q;

endmodule
`default_nettype wire

// File: tb/tb_sdr_rx_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdr_rx_demux : table-driven frame routing plus scoreboarded corner sequences
// rev 1.0
// ---------------------------------------------------------------------------
module tb_sdr_rx_demux;
  import sdr_pkg::*;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int          sink;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [7:0] ctrl;
    int         nb;
    logic [7:0] klast;
    int         sink;
    int         bytes;
    int         frames;
    int         drops;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdr_axil_if #(.ADDR_W(12)) axil ();
  sdr_axis_if #(.BYTES(8))   rx ();
  sdr_axis_if #(.BYTES(8))   dma ();
  sdr_axis_if #(.BYTES(8))   alt ();

  sdr_rx_demux #(
    .AXIL_ADDR_WIDTH (12),
    .AXIL_DATA_WIDTH (32),
    .AXIS_BYTES      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axil     (axil),
    .s_axis_rx  (rx),
    .m_axis_dma (dma),
    .m_axis_alt (alt)
  );

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    dma_mode = 0;   // 0: ready, 1: toggling, 2: stalled
  int    dma_vcnt = 0;
  int    alt_vcnt = 0;
  int    stall_err = 0;
  int    obs_rd = 0;
  bit    lat_chk = 1'b1;
  bit    chk_rdy = 1'b0;
  beat_t exp_q[$];
  beat_t obs_q[$];

  assign dma.tready = (dma_mode == 1) ? cyc[0] : (dma_mode == 0);
  assign alt.tready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  logic        pd_stall = 1'b0, pa_stall = 1'b0;
  logic [72:0] pd_pay, pa_pay;
  always @(negedge clk) begin
    if (rst) begin
      pd_stall <= 1'b0;
      pa_stall <= 1'b0;
    end else begin
      if (dma.tvalid) dma_vcnt <= dma_vcnt + 1;
      if (alt.tvalid) alt_vcnt <= alt_vcnt + 1;
      stall_err <= stall_err
        + int'(pd_stall && (!dma.tvalid || {dma.tdata, dma.tkeep, dma.tlast} != pd_pay))
        + int'(pa_stall && (!alt.tvalid || {alt.tdata, alt.tkeep, alt.tlast} != pa_pay));
      if (dma.tvalid && dma.tready) obs_q.push_back('{dma.tdata, dma.tkeep, dma.tlast, 0, cyc});
      if (alt.tvalid && alt.tready) obs_q.push_back('{alt.tdata, alt.tkeep, alt.tlast, 1, cyc});
      pd_stall <= dma.tvalid && !dma.tready;
      pa_stall <= alt.tvalid && !alt.tready;
      pd_pay   <= {dma.tdata, dma.tkeep, dma.tlast};
      pa_pay   <= {alt.tdata, alt.tkeep, alt.tlast};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done = 1'b0, w_done = 1'b0, ok = 1'b0, hs_aw, hs_w;
    axil.awaddr = a; axil.awvalid = 1'b1;
    axil.wdata = d;  axil.wstrb = s; axil.wvalid = 1'b1;
    axil.bready = 1'b1;
    for (int t = 0; t < 50 && !(aw_done && w_done); t++) begin
      @(negedge clk);
      hs_aw = axil.awvalid && axil.awready;
      hs_w  = axil.wvalid && axil.wready;
      @(posedge clk); #1;
      if (hs_aw) begin axil.awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin axil.wvalid = 1'b0;  w_done = 1'b1;  end
    end
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (axil.bvalid) begin
        chk("bresp", axil.bresp, 2'b00);
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    if (!ok) timeout("axil write");
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
    bit ok = 1'b0;
    d = 32'hX;
    axil.araddr = a; axil.arvalid = 1'b1; axil.rready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (axil.arready) begin ok = 1'b1; @(posedge clk); #1; break; end
    end
    axil.arvalid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (axil.rvalid) begin
          d = axil.rdata;
          chk("rresp", axil.rresp, 2'b00);
          ok = 1'b1;
          @(posedge clk); #1;
          break;
        end
      end
    end
    if (!ok) timeout("axil read");
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input int sink);
    bit ok = 1'b0;
    rx.tdata = d; rx.tkeep = k; rx.tlast = l; rx.tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (chk_rdy && t == 0) chk("drop tready", rx.tready, 1'b1);
      if (rx.tready) begin
        if (sink != 2) exp_q.push_back('{d, k, l, sink, cyc});
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    rx.tvalid = 1'b0;
    if (!ok) timeout("ingress beat");
  endtask

  task automatic drain(input string tag);
    beat_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int t = 0; t < 100 && obs_q.size() <= obs_rd; t++) @(posedge clk);
      if (obs_q.size() <= obs_rd) begin
        timeout({tag, " egress beat"});
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        chk({tag, " data"}, o.d, e.d);
        chk({tag, " keep/last/sink"}, {o.k, o.l, o.sink[1:0]}, {e.k, e.l, e.sink[1:0]});
        if (lat_chk) chk({tag, " latency"}, o.cyc, e.cyc + 1);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " no extra beats"}, obs_q.size(), obs_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t        tbl[6];
    logic [31:0] v, b0, f0, d0, b1, f1, d1;
    int          dv0, av0, se0, nb;

    tbl[0] = '{8'h01, 4, 8'hFF, 0, 32, 1, 0};
    tbl[1] = '{8'h11, 3, 8'h3C, 1, 20, 1, 0};
    tbl[2] = '{8'h21, 2, 8'h01, 2,  9, 0, 1};
    tbl[3] = '{8'h21, 1, 8'hFF, 2,  8, 0, 1};
    tbl[4] = '{8'hF1, 3, 8'h80, 2, 17, 0, 1};
    tbl[5] = '{8'h01, 1, 8'h0F, 0,  4, 1, 0};

    rst = 1'b1;
    rx.tvalid = 1'b0; rx.tdata = '0; rx.tkeep = '0; rx.tlast = 1'b0;
    axil.awvalid = 1'b0; axil.awaddr = '0; axil.wvalid = 1'b0; axil.wdata = '0;
    axil.wstrb = '0; axil.bready = 1'b0; axil.arvalid = 1'b0; axil.araddr = '0;
    axil.rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rx tready", rx.tready, 1'b0);
    chk("reset sink tvalid", {dma.tvalid, alt.tvalid}, 2'b00);
    chk("reset aw/w/ar ready", {axil.awready, axil.wready, axil.arready}, 3'b111);
    chk("reset b/r valid", {axil.bvalid, axil.rvalid}, 2'b00);
    chk("reset rdata", axil.rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    axil_read(REG_CTRL, v);
    chk("reset CTRL", v, 32'h0);

    // table: one frame per row, counter deltas and idle sink checked
    for (int i = 0; i < 6; i++) begin
      axil_write(REG_CTRL, {24'h0, tbl[i].ctrl}, 4'hF);
      axil_read(REG_RX_BYTES, b0);
      axil_read(REG_RX_FRAMES, f0);
      axil_read(REG_DROP_FRAMES, d0);
      dv0 = dma_vcnt; av0 = alt_vcnt;
      chk_rdy = (tbl[i].sink == 2);
      nb = tbl[i].nb;
      for (int j = 0; j < nb; j++)
        send_beat({$urandom, $urandom}, (j == nb - 1) ? tbl[i].klast : 8'hFF, j == nb - 1, tbl[i].sink);
      chk_rdy = 1'b0;
      drain("row");
      axil_read(REG_RX_BYTES, b1);
      axil_read(REG_RX_FRAMES, f1);
      axil_read(REG_DROP_FRAMES, d1);
      chk("row RX_BYTES delta", b1 - b0, tbl[i].bytes);
      chk("row RX_FRAMES delta", f1 - f0, tbl[i].frames);
      chk("row DROP_FRAMES delta", d1 - d0, tbl[i].drops);
      if (tbl[i].sink != 0) chk("row dma tvalid idle", dma_vcnt - dv0, 0);
      if (tbl[i].sink != 1) chk("row alt tvalid idle", alt_vcnt - av0, 0);
    end

    // CTRL change mid-frame affects only the next frame
    axil_write(REG_CTRL, 32'h01, 4'hF);
    send_beat(64'h1111_0000_0000_0001, 8'hFF, 1'b0, 0);
    send_beat(64'h1111_0000_0000_0002, 8'hFF, 1'b0, 0);
    axil_write(REG_CTRL, 32'h11, 4'hF);
    axil_read(REG_STATUS, v);
    chk("mid-frame IN_FRAME", v[1], 1'b1);
    send_beat(64'h1111_0000_0000_0003, 8'hFF, 1'b0, 0);
    send_beat(64'h1111_0000_0000_0004, 8'hFF, 1'b1, 0);
    send_beat(64'h2222_0000_0000_0001, 8'hFF, 1'b0, 1);
    send_beat(64'h2222_0000_0000_0002, 8'h07, 1'b1, 1);
    drain("midframe");
    axil_read(REG_STATUS, v);
    chk("idle IN_FRAME", v[1], 1'b0);

    // back-pressure on DMA, continuous ingress
    axil_write(REG_CTRL, 32'h01, 4'hF);
    se0 = stall_err;
    lat_chk = 1'b0;
    dma_mode = 1;
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < 8; j++)
        send_beat({$urandom, $urandom}, 8'hFF, j == 7, 0);
    drain("bp");
    chk("bp payload stable", stall_err - se0, 0);
    dma_mode = 0;
    lat_chk = 1'b1;

    // STATUS W1C lands in the same cycle as an accepted beat
    axil_read(REG_RX_BYTES, b0);
    axil_read(REG_STATUS, v);
    chk("running before W1C", v[0], 1'b1);
    axil.awaddr = REG_STATUS; axil.awvalid = 1'b1;
    axil.wdata = 32'h1; axil.wstrb = 4'hF; axil.wvalid = 1'b1; axil.bready = 1'b1;
    @(negedge clk);
    chk("W1C aw/w ready", {axil.awready, axil.wready}, 2'b11);
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    rx.tdata = 64'hABCD_0000_0000_0F0F; rx.tkeep = 8'h0F; rx.tlast = 1'b1; rx.tvalid = 1'b1;
    @(negedge clk);
    chk("W1C-cycle beat tready", rx.tready, 1'b1);
    exp_q.push_back('{rx.tdata, rx.tkeep, rx.tlast, 0, cyc});
    @(posedge clk); #1;
    rx.tvalid = 1'b0;
    begin
      bit ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        if (axil.bvalid) begin ok = 1'b1; @(posedge clk); #1; end
      end
      if (!ok) timeout("W1C bvalid");
    end
    drain("w1c");
    axil_read(REG_STATUS, v);
    chk("running set beats W1C", v[0], 1'b1);
    axil_read(REG_RX_BYTES, b1);
    chk("keep 0x0F byte delta", b1 - b0, 4);
    axil_write(REG_STATUS, 32'h1, 4'hF);
    axil_read(REG_STATUS, v);
    chk("running after W1C", v[0], 1'b0);

    // disabled while IDLE
    axil_write(REG_CTRL, 32'h00, 4'hF);
    rx.tdata = 64'h5; rx.tkeep = 8'hFF; rx.tlast = 1'b1; rx.tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("disabled tready", rx.tready, 1'b0);
    end
    @(posedge clk); #1;
    rx.tvalid = 1'b0;

    // asynchronous reset with a beat held in the slot
    axil_write(REG_CTRL, 32'h01, 4'hF);
    dma_mode = 2;
    send_beat(64'h7777_0000_0000_0001, 8'hFF, 1'b0, 0);
    @(negedge clk);
    chk("held beat before reset", dma.tvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("reset sink tvalid now", {dma.tvalid, alt.tvalid}, 2'b00);
    chk("reset rx tready now", rx.tready, 1'b0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    dma_mode = 0;
    obs_rd = obs_q.size();
    axil_read(REG_RX_BYTES, v);
    chk("reset RX_BYTES", v, 32'h0);
    axil_read(REG_RX_FRAMES, v);
    chk("reset RX_FRAMES", v, 32'h0);
    axil_read(REG_DROP_FRAMES, v);
    chk("reset DROP_FRAMES", v, 32'h0);
    axil_read(REG_STATUS, v);
    chk("reset STATUS", v, 32'h0);
    axil_read(12'h020, v);
    chk("unmapped read", v, 32'hDEAD_0020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
